// File: rtl/dma_burst_writer_if.sv
// Memory write channel between dma_burst_writer and the memory port:
// address, data and response handshakes (mem_bresp only with DMA_WR_ERR_EN).
interface dma_burst_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 8
);
  localparam int AWLEN_W = $clog2(MAX_BURST);

  logic                  mem_awvalid;
  logic                  mem_awready;
  logic [ADDR_WIDTH-1:0] mem_awaddr;
  logic [AWLEN_W-1:0]    mem_awlen;
  logic                  mem_wvalid;
  logic                  mem_wready;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wlast;
  logic                  mem_bvalid;
  logic                  mem_bready;
`ifdef DMA_WR_ERR_EN
  logic [1:0]            mem_bresp;

  modport master (
    output mem_awvalid, mem_awaddr, mem_awlen,
    input  mem_awready,
    output mem_wvalid, mem_wdata, mem_wlast,
    input  mem_wready,
    input  mem_bvalid, mem_bresp,
    output mem_bready
  );

  modport slave (
    input  mem_awvalid, mem_awaddr, mem_awlen,
    output mem_awready,
    input  mem_wvalid, mem_wdata, mem_wlast,
    output mem_wready,
    output mem_bvalid, mem_bresp,
    input  mem_bready
  );
`else
  modport master (
    output mem_awvalid, mem_awaddr, mem_awlen,
    input  mem_awready,
    output mem_wvalid, mem_wdata, mem_wlast,
    input  mem_wready,
    input  mem_bvalid,
    output mem_bready
  );

  modport slave (
    input  mem_awvalid, mem_awaddr, mem_awlen,
    output mem_awready,
    input  mem_wvalid, mem_wdata, mem_wlast,
    output mem_wready,
    output mem_bvalid,
    input  mem_bready
  );
`endif
endinterface

// File: rtl/dma_burst_writer.sv
// Drains the DMA data FIFO into address/data/response write bursts of up to MAX_BURST beats.
// Define DMA_WR_ERR_EN to add mem_bresp checking with a sticky wr_err flag.
module dma_burst_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  xfer_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
`ifdef DMA_WR_ERR_EN
  output logic [0:0]            wr_err,
`endif
  dma_burst_writer_if.master    mem
);
  localparam int CNT_W   = $clog2(MAX_BURST) + 1;
  localparam int AWLEN_W = $clog2(MAX_BURST);
  localparam int BYTES   = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [CNT_W-1:0]      burst_beats;
  logic [CNT_W-1:0]      fetched;
  logic [CNT_W-1:0]      sent;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic [1:0]            occ;
  logic                  in_flight;
  logic                  awvalid_q;
  logic                  bready_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  w_fire;
  logic                  b_err;
  logic [2:0]            level;
  logic [LEN_WIDTH-1:0]  rem_next;
  logic [ADDR_WIDTH-1:0] addr_next;

  function automatic logic [CNT_W-1:0] burst_size(input logic [LEN_WIDTH-1:0] rem);
    if (rem >= LEN_WIDTH'(MAX_BURST)) return CNT_W'(MAX_BURST);
    return CNT_W'(rem);
  endfunction

  assign mem.mem_awvalid = awvalid_q;
  assign mem.mem_awaddr  = cur_addr;
  assign mem.mem_awlen   = AWLEN_W'(burst_beats - CNT_W'(1));
  assign mem.mem_wvalid  = (occ != 2'd0);
  assign mem.mem_wdata   = buf0;
  assign mem.mem_wlast   = (occ != 2'd0) && (sent == burst_beats - CNT_W'(1));
  assign mem.mem_bready  = bready_q;
  assign busy            = busy_q;
  assign done            = done_q;

  assign w_fire    = mem.mem_wvalid && mem.mem_wready;
  assign rem_next  = remaining - LEN_WIDTH'(burst_beats);
  assign addr_next = cur_addr + ADDR_WIDTH'(burst_beats) * ADDR_WIDTH'(BYTES);

  // The beat leaving this cycle frees its slot now, so a read may overlap the
  // departure; without that the 2-entry buffer could not sustain one beat/cycle.
  assign level     = 3'(occ) + 3'(in_flight) - 3'(w_fire);
  assign fifo_r_en = (state == W) && !fifo_empty && (fetched < burst_beats) && (level < 3'd2);

`ifdef DMA_WR_ERR_EN
  assign b_err = (mem.mem_bresp != 2'b00);
`else
  assign b_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      burst_beats <= '0;
      fetched     <= '0;
      sent        <= '0;
      buf0        <= '0;
      buf1        <= '0;
      occ         <= '0;
      in_flight   <= 1'b0;
      awvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      in_flight <= fifo_r_en;
      if (fifo_r_en) fetched <= fetched + CNT_W'(1);
      if (w_fire)    sent    <= sent + CNT_W'(1);

      // Skid buffer: buf0 is the head; returning read data fills the first free slot.
      unique case ({in_flight, w_fire})
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_data;
          else             buf1 <= fifo_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= fifo_data;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_data;
          end
        end
        default: ;
      endcase

      unique case (state)
        IDLE: if (start) begin
          cur_addr  <= dst_addr;
          remaining <= xfer_len;
          if (xfer_len == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state       <= AW;
            busy_q      <= 1'b1;
            awvalid_q   <= 1'b1;
            burst_beats <= burst_size(xfer_len);
          end
        end
        AW: if (mem.mem_awready) begin
          awvalid_q <= 1'b0;
          fetched   <= '0;
          sent      <= '0;
          state     <= W;
        end
        W: if (w_fire && mem.mem_wlast) begin
          bready_q <= 1'b1;
          state    <= B;
        end
        B: if (mem.mem_bvalid) begin
          bready_q  <= 1'b0;
          remaining <= rem_next;
          cur_addr  <= addr_next;
          if (b_err || rem_next == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            state       <= AW;
            awvalid_q   <= 1'b1;
            burst_beats <= burst_size(rem_next);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMA_WR_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)                                          wr_err <= '0;
    else if (state == IDLE && start)                  wr_err <= '0;
    else if (state == B && mem.mem_bvalid && b_err)   wr_err <= 1'b1;
  end
`endif
endmodule
